// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: transmit state encoding, parity type codes,
// counter widths and small helper functions used by the TX serializer.
package uart_pkg;

  // Clocks-per-bit field width; prescale values 0..63 (0 behaves as 1).
  localparam int PRESCALE_W = 6;
  // Bit counter width; holds 0..DATA_WIDTH with DATA_WIDTH up to 9.
  localparam int BIT_CNT_W  = 4;
  // Widest data word the serializer supports.
  localparam int MAX_DATA_W = 9;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Parity bit for a (zero-extended) data word: even -> XOR of bits, odd -> XNOR.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                      input logic                  ptype);
    logic p;
    p = ^data;
    if (ptype == PARITY_ODD) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

  // A prescale of zero would stall the baud counter, so it is promoted to one.
  function automatic logic [PRESCALE_W-1:0] eff_prescale(input logic [PRESCALE_W-1:0] p);
    if (p == 6'd0) begin
      return 6'd1;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Handshake and configuration bundle between a word producer and the UART
// transmit serializer. The producer drives the master side; the serializer
// uses the slave side and returns the serial line and busy flag.
interface uart_tx_serializer_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);

  logic [PRESCALE_W-1:0] prescale;
  logic                  parity_enable;
  logic                  parity_type;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output prescale,
    output parity_enable,
    output parity_type,
    output data_in,
    output data_valid,
    input  tx_out,
    input  busy
  );

  modport slave (
    input  prescale,
    input  parity_enable,
    input  parity_type,
    input  data_in,
    input  data_valid,
    output tx_out,
    output busy
  );

endinterface

// File: rtl/uart_tx_serializer_baud_counter.sv
// Bit timing for the UART transmitter. The edge counter runs 1..P while
// enabled and pulses o_bit_done on the last clock of each bit period; the bit
// counter advances on that pulse while i_count_bit is set. i_start preloads
// the edge counter so the very first frame clock already counts as edge 1.
module uart_tx_baud_counter
  import uart_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_enable,
  input  logic                  i_count_bit,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_bit_done,
  output logic [BIT_CNT_W-1:0]  o_bit_cnt
);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  w_bit_done;

  assign w_bit_done = i_enable && (r_edge_cnt == i_prescale);
  assign o_bit_done = w_bit_done;
  assign o_bit_cnt  = r_bit_cnt;

  // Edge counter wraps P -> 1 each bit; bit counter steps on completed data bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_edge_cnt <= 6'd0;
      r_bit_cnt  <= 4'd0;
    end else if (i_start) begin
      r_edge_cnt <= 6'd1;
      r_bit_cnt  <= 4'd0;
    end else if (i_enable) begin
      if (w_bit_done) begin
        r_edge_cnt <= 6'd1;
        if (i_count_bit) begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else begin
          r_bit_cnt <= r_bit_cnt;
        end
      end else begin
        r_edge_cnt <= r_edge_cnt + 6'd1;
        r_bit_cnt  <= r_bit_cnt;
      end
    end else begin
      r_edge_cnt <= 6'd0;
      r_bit_cnt  <= 4'd0;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer. Accepts a word on a valid/busy handshake and sends
// it LSB first: start bit, data bits, optional parity bit, one stop bit, each
// lasting P clocks (P = prescale latched at acceptance, 0 treated as 1).
// tx_out and busy are registered; the start bit appears on the clock right
// after the acceptance edge and busy falls on the last stop-bit clock edge.
// Build option: define UART_TX_PARITY_EN to build the parity state and honour
// parity_enable/parity_type; otherwise those inputs are ignored and every frame
// is start + data + stop.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
)(
  input  logic                  clock,
  input  logic                  reset,
  uart_tx_serializer_if.slave   bus
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  tx_state_e             r_state;
  tx_state_e             w_next_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_tx;
  logic                  w_tx_next;
  logic                  r_busy;
  logic                  w_accept;
  logic                  w_start;
  logic                  w_run;
  logic                  w_count_bit;
  logic                  w_bit_done;
  logic [BIT_CNT_W-1:0]  w_bit_cnt;

`ifdef UART_TX_PARITY_EN
  logic                  r_par_en;
  logic                  r_par_bit;
  logic [MAX_DATA_W-1:0] w_data_ext;

  assign w_data_ext = MAX_DATA_W'(bus.data_in);
`endif

  // A new word is only taken while the line is idle; requests during a frame are dropped.
  assign w_accept    = (r_state == IDLE) && bus.data_valid && !r_busy;
  assign w_run       = (r_state != IDLE);
  assign w_count_bit = (r_state == DATA);

  assign bus.tx_out  = r_tx;
  assign bus.busy    = r_busy;

  uart_tx_baud_counter u_baud (
    .clock       (clock),
    .reset       (reset),
    .i_start     (w_start),
    .i_enable    (w_run),
    .i_count_bit (w_count_bit),
    .i_prescale  (r_prescale),
    .o_bit_done  (w_bit_done),
    .o_bit_cnt   (w_bit_cnt)
  );

  // Next state, next shift contents and the line level for the following clock.
  always_comb begin
    w_next_state = r_state;
    w_shift_next = r_shift;
    w_tx_next    = 1'b1;
    w_start      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = START;
          w_shift_next = bus.data_in;
          w_tx_next    = 1'b0;
          w_start      = 1'b1;
        end else begin
          w_tx_next    = 1'b1;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_next_state = DATA;
          w_tx_next    = r_shift[0];
        end else begin
          w_tx_next    = 1'b0;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_next = r_shift >> 1;
          if (w_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            if (r_par_en) begin
              w_next_state = PARITY;
              w_tx_next    = r_par_bit;
            end else begin
              w_next_state = STOP;
              w_tx_next    = 1'b1;
            end
`else
            w_next_state = STOP;
            w_tx_next    = 1'b1;
`endif
          end else begin
            // Next data bit is the one that moves into position 0.
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_tx_next    = r_shift[0];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_done) begin
          w_next_state = STOP;
          w_tx_next    = 1'b1;
        end else begin
          w_tx_next    = r_par_bit;
        end
      end
`endif
      STOP: begin
        w_tx_next = 1'b1;
        if (w_bit_done) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = STOP;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  // FSM state, serial line, busy flag and shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_shift <= '0;
    end else begin
      r_state <= w_next_state;
      r_tx    <= w_tx_next;
      r_busy  <= (w_next_state != IDLE);
      r_shift <= w_shift_next;
    end
  end

  // Frame settings captured at acceptance so mid-frame input changes are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prescale <= 6'd0;
    end else if (w_start) begin
      r_prescale <= eff_prescale(bus.prescale);
    end else begin
      r_prescale <= r_prescale;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity enable and parity value of the accepted word, held for the whole frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_start) begin
      r_par_en  <= bus.parity_enable;
      r_par_bit <= parity_bit(w_data_ext, bus.parity_type);
    end else begin
      r_par_en  <= r_par_en;
      r_par_bit <= r_par_bit;
    end
  end
`endif

endmodule
